// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
// Holds the state encoding, ALU operation codes, opcodes and datapath mux codes.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UPPER    = 4'd12,
        S_MDWAIT   = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_MULH = 4'd11,
        ALU_DIV  = 4'd12,
        ALU_REM  = 4'd13
    } alu_op_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Branch outcome from funct3; the 01x encodings are rejected by the FSM.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic lt, input logic ltu);
        case (f3)
            3'b000:  return zero;
            3'b001:  return ~zero;
            3'b100:  return lt;
            3'b101:  return ~lt;
            3'b110:  return ltu;
            3'b111:  return ~ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mcu_alu_decoder.sv
// Combinational ALU-operation decoder: op/funct3/funct7 -> ALU op code and illegal flag.
// MULDIV_EN enables the M-extension encodings (funct7 = 0000001 on R-type).
module mcu_alu_decoder
    import mcu_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_t    alu_op,
    output logic       illegal
);

    // is_r selects SUB for funct3=000; immediates never subtract.
    function automatic alu_op_t base_op(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'b000:  return (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (op)
            OP_R: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    alu_op = base_op(funct3, funct7[5], 1'b1);
                end
`ifdef MULDIV_EN
                else if (funct7 == F7_MULDIV) begin
                    case (funct3)
                        3'b000:  alu_op = ALU_MUL;
                        3'b001:  alu_op = ALU_MULH;
                        3'b100:  alu_op = ALU_DIV;
                        3'b110:  alu_op = ALU_REM;
                        default: illegal = 1'b1;
                    endcase
                end
`endif
                else begin
                    illegal = 1'b1;
                end
            end
            OP_I:                                      alu_op = base_op(funct3, funct7[5], 1'b0);
            OP_LOAD, OP_STORE, OP_B, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC:                          alu_op = ALU_ADD;
            default:                                   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: instruction sequencing FSM with memory handshake timeout and sticky trap.
// MULDIV_EN adds the MDWAIT state and the md_done input for multi-cycle multiply/divide.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | ALUOut <= oldPC + imm (branch/jal target), dispatch on op
// MEMADR   | ALUOut <= rs1 + imm
// MEMREAD  | load request at ALUOut
// MEMWB    | rd <= memory data
// MEMWRITE | store request at ALUOut
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
// JAL      | PC <= ALUOut, ALUOut <= oldPC + 4
// JALR     | PC <= rs1 + imm
// UPPER    | ALUOut <= oldPC/x0 + U-imm
// MDWAIT   | hold mul/div controls until md_done
// TRAP     | fault, absorbing until reset
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALUCTRL_W   = 4,
    parameter int MEM_TIMEOUT = 255
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
`ifdef MULDIV_EN
    input  logic                 md_done,
`endif
    output logic                 mem_req,
    output logic                 memwrite,
    output logic                 adrsrc,
    output logic                 irwrite,
    output logic                 pcwrite,
    output logic                 regwrite,
    output logic [1:0]           alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           resultsrc,
    output logic [2:0]           immsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 fault,
    output logic [3:0]           state_o
);

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state, state_next;
    alu_op_t     dec_op, alu_op;
    logic        dec_illegal;
    logic        mem_phase, stall, timeout;
    logic [15:0] tmo_cnt;

    mcu_alu_decoder u_dec (
        .op      (op),
        .funct3  (funct3),
        .funct7  (funct7),
        .alu_op  (dec_op),
        .illegal (dec_illegal)
    );

    assign mem_phase = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign stall     = mem_phase && !mem_ready;
    // Fires on the last allowed stalled cycle, so a late mem_ready still wins.
    assign timeout   = stall && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   tmo_cnt <= '0;
        else if (stall && !timeout) tmo_cnt <= tmo_cnt + 16'd1;
        else                        tmo_cnt <= '0;
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        adrsrc     = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RS2;
        resultsrc  = RES_ALUOUT;
        immsrc     = IMM_I;
        alu_op     = ALU_ADD;
        fault      = 1'b0;
        // Outputs stay quiet while reset is held, so an access in flight is dropped at once.
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alusrcb   = SRCB_FOUR;
                    resultsrc = RES_ALU;
                    if (mem_ready) begin
                        irwrite    = 1'b1;
                        pcwrite    = 1'b1;
                        state_next = S_DECODE;
                    end else if (timeout) begin
                        state_next = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alusrca = SRCA_OLDPC;
                    alusrcb = SRCB_IMM;
                    if (op == OP_B)        immsrc = IMM_B;
                    else if (op == OP_JAL) immsrc = IMM_J;
                    if (dec_illegal) begin
                        state_next = S_TRAP;
                    end else begin
                        case (op)
                            OP_LOAD, OP_STORE: state_next = S_MEMADR;
                            OP_R:              state_next = S_EXECR;
                            OP_I:              state_next = S_EXECI;
                            OP_B:              state_next = S_BRANCH;
                            OP_JAL:            state_next = S_JAL;
                            OP_JALR:           state_next = S_JALR;
                            OP_LUI, OP_AUIPC:  state_next = S_UPPER;
                            default:           state_next = S_TRAP;
                        endcase
                    end
                end
                S_MEMADR: begin
                    alusrca    = SRCA_RS1;
                    alusrcb    = SRCB_IMM;
                    immsrc     = (op == OP_STORE) ? IMM_S : IMM_I;
                    state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adrsrc  = 1'b1;
                    if (mem_ready)    state_next = S_MEMWB;
                    else if (timeout) state_next = S_TRAP;
                end
                S_MEMWB: begin
                    resultsrc  = RES_MEM;
                    regwrite   = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    memwrite = 1'b1;
                    adrsrc   = 1'b1;
                    if (mem_ready)    state_next = S_FETCH;
                    else if (timeout) state_next = S_TRAP;
                end
                S_EXECR: begin
                    alusrca    = SRCA_RS1;
                    alu_op     = dec_op;
                    state_next = S_ALUWB;
`ifdef MULDIV_EN
                    if (funct7 == F7_MULDIV) state_next = S_MDWAIT;
`endif
                end
`ifdef MULDIV_EN
                S_MDWAIT: begin
                    alusrca = SRCA_RS1;
                    alu_op  = dec_op;
                    if (md_done) state_next = S_ALUWB;
                end
`endif
                S_EXECI: begin
                    alusrca    = SRCA_RS1;
                    alusrcb    = SRCB_IMM;
                    alu_op     = dec_op;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    regwrite   = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    alusrca = SRCA_RS1;
                    immsrc  = IMM_B;
                    alu_op  = ALU_SUB;
                    if (funct3[2:1] == 2'b01) begin
                        state_next = S_TRAP;
                    end else begin
                        pcwrite    = branch_taken(funct3, zero, lt, ltu);
                        state_next = S_FETCH;
                    end
                end
                S_JAL: begin
                    alusrca    = SRCA_OLDPC;
                    alusrcb    = SRCB_FOUR;
                    immsrc     = IMM_J;
                    pcwrite    = 1'b1;
                    state_next = S_ALUWB;
                end
                S_JALR: begin
                    alusrca    = SRCA_RS1;
                    alusrcb    = SRCB_IMM;
                    resultsrc  = RES_ALU;
                    pcwrite    = 1'b1;
                    state_next = S_JAL;
                end
                S_UPPER: begin
                    // lui reads rs1 with the register field forced to x0 by the datapath.
                    alusrca    = (op == OP_AUIPC) ? SRCA_OLDPC : SRCA_RS1;
                    alusrcb    = SRCB_IMM;
                    immsrc     = IMM_U;
                    state_next = S_ALUWB;
                end
                S_TRAP: begin
                    fault      = 1'b1;
                    state_next = S_TRAP;
                end
                default: state_next = S_TRAP;
            endcase
        end
    end

    assign alucontrol = ALUCTRL_W'(alu_op);
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (default build, MEM_TIMEOUT = 4).
module tb_multicycle_control_unit;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4;
    localparam int ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7, ST_ALUWB = 8, ST_BRANCH = 9;
    localparam int ST_JAL = 10, ST_UPPER = 12, ST_TRAP = 14;

    logic       clk, rst;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    logic       zero, lt, ltu, mem_ready, md_done;
    logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, fault;
    logic [1:0] alusrca, alusrcb, resultsrc;
    logic [2:0] immsrc;
    logic [3:0] alucontrol, state_o;

    int checks   = 0;
    int failures = 0;

    multicycle_control_unit #(.ALUCTRL_W(4), .MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .mem_ready  (mem_ready),
`ifdef MULDIV_EN
        .md_done    (md_done),
`endif
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .adrsrc     (adrsrc),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .immsrc     (immsrc),
        .alucontrol (alucontrol),
        .fault      (fault),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_fetch(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        op = o; funct3 = f3; funct7 = f7; mem_ready = 1'b1;
        #1;
        chk("fetch_state", state_o, ST_FETCH);
        chk("fetch_ir_pc", {irwrite, pcwrite, mem_req}, 3'b111);
        cyc();
        chk("decode_state", state_o, ST_DECODE);
        cyc();
    endtask

    task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic [6:0] f7, input int exp_state, input logic [1:0] exp_b,
                           input logic [3:0] exp_alu);
        do_fetch(o, f3, f7);
        chk({tag, "_state"}, state_o, exp_state);
        chk({tag, "_alu"}, alucontrol, exp_alu);
        chk({tag, "_srcab"}, {alusrca, alusrcb}, {2'b10, exp_b});
        chk({tag, "_nowb"}, regwrite, 1'b0);
        cyc();
        chk({tag, "_wb"}, {state_o, regwrite, resultsrc}, {4'd8, 1'b1, 2'b00});
        cyc();
    endtask

    task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                              input logic l, input logic lu, input logic exp_pc);
        zero = z; lt = l; ltu = lu;
        do_fetch(7'b1100011, f3, 7'b0);
        chk({tag, "_state"}, state_o, ST_BRANCH);
        chk({tag, "_pcwrite"}, pcwrite, exp_pc);
        chk({tag, "_alu"}, alucontrol, 4'd1);
        cyc();
        chk({tag, "_back"}, state_o, ST_FETCH);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("reset_fault", fault, 1'b0);
        chk("reset_state", state_o, ST_FETCH);
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        logic [4:0] seen;
        rst = 1'b0; op = 7'b0; funct3 = 3'b0; funct7 = 7'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0; md_done = 1'b0;

        #3;
        chk("rst_state", state_o, ST_FETCH);
        chk("rst_enables", {mem_req, memwrite, irwrite, pcwrite, regwrite, fault}, 6'b0);
        chk("rst_muxes", {adrsrc, alusrca, alusrcb, resultsrc, immsrc}, 12'b0);
        chk("rst_alu", alucontrol, 4'd0);

        @(posedge clk); #2;
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("fetch_muxes", {alusrca, alusrcb, resultsrc, adrsrc}, {2'b00, 2'b10, 2'b10, 1'b0});

        // add, sub, srai, addi with funct7[5] set, and, sltiu
        run_alu("add",   7'b0110011, 3'b000, 7'b0000000, ST_EXECR, 2'b00, 4'd0);
        run_alu("sub",   7'b0110011, 3'b000, 7'b0100000, ST_EXECR, 2'b00, 4'd1);
        run_alu("srai",  7'b0010011, 3'b101, 7'b0100000, ST_EXECI, 2'b01, 4'd9);
        run_alu("addi",  7'b0010011, 3'b000, 7'b0100000, ST_EXECI, 2'b01, 4'd0);
        run_alu("and",   7'b0110011, 3'b111, 7'b0000000, ST_EXECR, 2'b00, 4'd2);
        run_alu("sltiu", 7'b0010011, 3'b011, 7'b0000000, ST_EXECI, 2'b01, 4'd6);

        // lw: mem_ready arrives on the 4th MEMREAD cycle, exactly the timeout boundary
        do_fetch(7'b0000011, 3'b010, 7'b0);
        chk("lw_memadr", {state_o, alusrca, alusrcb, immsrc}, {4'd2, 2'b10, 2'b01, 3'b000});
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_wait", {state_o, mem_req, adrsrc}, {4'd3, 1'b1, 1'b1});
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_ready", {state_o, mem_req}, {4'd3, 1'b1});
        cyc();
        chk("lw_memwb", {state_o, regwrite, resultsrc}, {4'd4, 1'b1, 2'b01});
        cyc();
        chk("lw_back", state_o, ST_FETCH);

        run_branch("bne_z1",  3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        run_branch("bne_z0",  3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        run_branch("blt_lt",  3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
        run_branch("bgeu_lu", 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
        run_branch("beq_z1",  3'b000, 1'b1, 1'b0, 1'b0, 1'b1);

        // jal: target into PC, then rd <= oldPC+4
        do_fetch(7'b1101111, 3'b000, 7'b0);
        chk("jal_state", {state_o, pcwrite, alusrca, alusrcb}, {4'd10, 1'b1, 2'b01, 2'b10});
        cyc();
        chk("jal_wb", {state_o, regwrite}, {4'd8, 1'b1});
        cyc();

        do_fetch(7'b0110111, 3'b000, 7'b0);
        chk("lui", {state_o, immsrc, alusrca, alucontrol}, {4'd12, 3'b100, 2'b10, 4'd0});
        cyc(); cyc();
        do_fetch(7'b0010111, 3'b000, 7'b0);
        chk("auipc", {state_o, immsrc, alusrca}, {4'd12, 3'b100, 2'b01});
        cyc(); cyc();

        // illegal opcode: DECODE then TRAP, never any write enable
        op = 7'b0000000; funct3 = 3'b0; funct7 = 7'b0; mem_ready = 1'b1;
        cyc();
        seen = 5'b0;
        #1;
        chk("illop_decode", state_o, ST_DECODE);
        seen |= {regwrite, pcwrite, memwrite, irwrite, mem_req};
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            seen |= {regwrite, pcwrite, memwrite, irwrite, mem_req};
            chk("illop_trap", {state_o, fault}, {4'd14, 1'b1});
            cyc();
        end
        chk("illop_no_enables", seen, 5'b0);
        do_reset();

        // funct7 = 0000001 without the M extension traps from DECODE
        do_fetch(7'b0110011, 3'b000, 7'b0000001);
        chk("muldiv_trap", {state_o, fault}, {4'd14, 1'b1});
        do_reset();

        // reserved branch funct3 traps from BRANCH without taking
        do_fetch(7'b1100011, 3'b010, 7'b0);
        chk("br010_pc", {state_o, pcwrite}, {4'd9, 1'b0});
        cyc();
        chk("br010_trap", state_o, ST_TRAP);

        // timeout in FETCH after 4 stalled cycles
        mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tmo_stall", {state_o, mem_req}, {4'd0, 1'b1});
            cyc();
        end
        #1;
        chk("tmo_trap", {state_o, fault, mem_req}, {4'd14, 1'b1, 1'b0});
        do_reset();

        // reset in the middle of a store drops mem_req immediately
        do_fetch(7'b0100011, 3'b010, 7'b0);
        chk("sw_memadr", {state_o, immsrc}, {4'd2, 3'b001});
        cyc();
        mem_ready = 1'b0;
        #1;
        chk("sw_memwrite", {state_o, mem_req, memwrite, adrsrc}, {4'd5, 1'b1, 1'b1, 1'b1});
        rst = 1'b0;
        #1;
        chk("sw_rst_drop", {state_o, mem_req, memwrite}, {4'd0, 1'b0, 1'b0});
        cyc();
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
